// File: rtl/car_warn_pkg.sv
// Shared types and constants for the car-warning chime path.
package car_warn_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEEP_ON  = 2'd1,
    BEEP_OFF = 2'd2,
    HOLD     = 2'd3
  } chime_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/chime_timer.sv
// Loadable down-counter shared by the ON and OFF beep phases.
module chime_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/car_chime_driver.sv
// Buzzer pattern generator for the car-warning alarm line.
// Optional start qualification filter enabled by defining CHIME_FILTER_EN.
module car_chime_driver
  import car_warn_pkg::*;
#(
  parameter int unsigned ON_CYC     = 8,
  parameter int unsigned OFF_CYC    = 8,
  parameter int unsigned MAX_BEEPS  = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned BEEP_W     = 5,
  parameter int unsigned FILTER_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alarm_req,
  input  logic              ignition,
  input  logic              ack,
  output logic              buzzer,
  output logic              active,
  output logic              timeout,
  output logic [BEEP_W-1:0] beep_cnt
);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYC - 1);
  localparam logic [BEEP_W-1:0] MAX_CNT  = BEEP_W'(MAX_BEEPS);

  if ((ON_CYC < 1) || (OFF_CYC < 1) || (MAX_BEEPS < 1) || (FILTER_CYC < 1)) begin : g_param_check
    $error("car_chime_driver: cycle/beep parameters must be >= 1");
  end

  logic [SYNC_STAGES-1:0] alarm_sync_q, alarm_sync_d;
  logic [SYNC_STAGES-1:0] ign_sync_q, ign_sync_d;
  logic                   req;
  logic                   start_ok;

  chime_state_t      state_q, state_d;
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic              buzzer_q, buzzer_d;
  logic              active_q, active_d;
  logic              timeout_q, timeout_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             expire_hold;

  always_comb begin
    alarm_sync_d = {alarm_sync_q[SYNC_STAGES-2:0], alarm_req};
    ign_sync_d   = {ign_sync_q[SYNC_STAGES-2:0], ignition};
  end

  assign req = alarm_sync_q[SYNC_STAGES-1] & ign_sync_q[SYNC_STAGES-1];

`ifdef CHIME_FILTER_EN
  localparam int unsigned      FILT_W   = $clog2(FILTER_CYC + 1);
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_CYC);

  logic [FILT_W-1:0] filt_q, filt_d;

  // Saturating count of consecutive req cycles; a pattern may start only
  // once FILTER_CYC qualified cycles have already been seen.
  always_comb begin
    filt_d = filt_q;
    if (!req) begin
      filt_d = '0;
    end else if (filt_q != FILT_MAX) begin
      filt_d = filt_q + FILT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end

  assign start_ok = (filt_q == FILT_MAX);
`else
  assign start_ok = 1'b1;
`endif

  chime_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .dec   (tmr_dec),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_sync_q <= '0;
      ign_sync_q   <= '0;
      state_q      <= IDLE;
      beep_cnt_q   <= '0;
      buzzer_q     <= 1'b0;
      active_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      alarm_sync_q <= alarm_sync_d;
      ign_sync_q   <= ign_sync_d;
      state_q      <= state_d;
      beep_cnt_q   <= beep_cnt_d;
      buzzer_q     <= buzzer_d;
      active_q     <= active_d;
      timeout_q    <= timeout_d;
    end
  end

  // req drop outranks ack, which outranks phase expiry.
  always_comb begin
    state_d     = state_q;
    beep_cnt_d  = beep_cnt_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;
    tmr_dec     = 1'b0;
    expire_hold = 1'b0;
    if (!req) begin
      state_d    = IDLE;
      beep_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_d    = BEEP_ON;
            tmr_load   = 1'b1;
            tmr_value  = ON_LOAD;
            beep_cnt_d = BEEP_W'(1);
          end
        end
        BEEP_ON: begin
          if (ack) begin
            state_d = HOLD;
          end else if (tmr_zero) begin
            state_d   = BEEP_OFF;
            tmr_load  = 1'b1;
            tmr_value = OFF_LOAD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        BEEP_OFF: begin
          if (ack) begin
            state_d = HOLD;
          end else if (tmr_zero) begin
            if (beep_cnt_q == MAX_CNT) begin
              state_d     = HOLD;
              expire_hold = 1'b1;
            end else begin
              state_d    = BEEP_ON;
              tmr_load   = 1'b1;
              tmr_value  = ON_LOAD;
              beep_cnt_d = beep_cnt_q + BEEP_W'(1);
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d    = IDLE;
          beep_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    buzzer_d  = (state_d == BEEP_ON);
    active_d  = (state_d == BEEP_ON) || (state_d == BEEP_OFF);
    timeout_d = (state_d == HOLD) && ((state_q == HOLD) ? timeout_q : expire_hold);
  end

  assign buzzer   = buzzer_q;
  assign active   = active_q;
  assign timeout  = timeout_q;
  assign beep_cnt = beep_cnt_q;

endmodule
